// File: rtl/irq_priority_ctrl_pkg.sv
// rtl/irq_priority_ctrl_pkg.sv - shared constants, FSM encoding and cfg layout for the IRQ controller
package irq_priority_ctrl_pkg;

    localparam int N_IRQ_DEF = 3;
    localparam int ID_W      = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } irq_state_e;

    // cfg_wdata layout: per-source enables in [n-1:0], global ie directly above them
    function automatic int cfg_ie_bit(input int n);
        return n;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - priority encoder: index of the highest set bit plus a valid flag
module irq_prio_enc
    import irq_priority_ctrl_pkg::*;
#(
    parameter int N     = N_IRQ_DEF,
    parameter int IDX_W = ID_W
) (
    input  logic [N-1:0]     vec_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    // ascending scan: the last set bit seen is the highest one
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int i = 0; i < N; i++) begin
            if (vec_i[i]) begin
                valid_o = 1'b1;
                idx_o   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_priority_ctrl.sv
// rtl/irq_priority_ctrl.sv - nested priority interrupt controller: edge capture, one request at a time, in-service tracking
module irq_priority_ctrl
    import irq_priority_ctrl_pkg::*;
#(
    parameter int               N_IRQ      = N_IRQ_DEF,
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] VEC_BASE   = 32'h0000_0100,
    parameter logic [WIDTH-1:0] VEC_STRIDE = 32'h0000_0010
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] IRQ,
    input  logic             cfg_we,
    input  logic [N_IRQ:0]   cfg_wdata,
    input  logic             int_ack,
    input  logic             int_ret,
    output logic             int_req,
    output logic [ID_W-1:0]  int_id,
    output logic [WIDTH-1:0] int_vec,
    output logic [N_IRQ-1:0] IRW
);

    localparam int IE_BIT = cfg_ie_bit(N_IRQ);

    irq_state_e       state_q, state_d;
    logic [N_IRQ-1:0] irq_q;
    logic [N_IRQ-1:0] pending_q, pending_d;
    logic [N_IRQ-1:0] irw_q, irw_d;
    logic [N_IRQ-1:0] mask_q;
    logic             ie_q;
    logic             req_q, req_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [WIDTH-1:0] vec_q, vec_d;

    logic             cur_valid, cand_valid, eligible;
    logic [ID_W-1:0]  cur_idx, cand_idx;
    logic [N_IRQ-1:0] irq_edge;

    assign irq_edge = IRQ & ~irq_q;

    irq_prio_enc #(.N(N_IRQ), .IDX_W(ID_W)) u_cur_enc (
        .vec_i   (irw_q),
        .valid_o (cur_valid),
        .idx_o   (cur_idx)
    );

    irq_prio_enc #(.N(N_IRQ), .IDX_W(ID_W)) u_cand_enc (
        .vec_i   (pending_q & mask_q),
        .valid_o (cand_valid),
        .idx_o   (cand_idx)
    );

    // strictly above the current in-service level; no same-level re-entry
    assign eligible = ie_q && cand_valid && (!cur_valid || (cand_idx > cur_idx));

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        id_d      = id_q;
        vec_d     = vec_q;
        pending_d = pending_q;
        irw_d     = irw_q;

        if (int_ret && cur_valid) begin
            irw_d[cur_idx] = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (eligible) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                    id_d    = cand_idx;
                    vec_d   = VEC_BASE + WIDTH'(cand_idx) * VEC_STRIDE;
                end
            end
            ST_REQ: begin
                if (int_ack) begin
                    pending_d[id_q] = 1'b0;
                    irw_d[id_q]     = 1'b1;
                    req_d           = 1'b0;
                    state_d         = ST_IDLE;
                end else if (!ie_q || !mask_q[id_q]) begin
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // a fresh edge overrides the ack clear of the same source
        pending_d = pending_d | irq_edge;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            irq_q     <= '1;
            pending_q <= '0;
            irw_q     <= '0;
            ie_q      <= 1'b1;
            mask_q    <= '1;
            req_q     <= 1'b0;
            id_q      <= '0;
            vec_q     <= VEC_BASE;
        end else begin
            state_q   <= state_d;
            irq_q     <= IRQ;
            pending_q <= pending_d;
            irw_q     <= irw_d;
            req_q     <= req_d;
            id_q      <= id_d;
            vec_q     <= vec_d;
            if (cfg_we) begin
                ie_q   <= cfg_wdata[IE_BIT];
                mask_q <= cfg_wdata[N_IRQ-1:0];
            end
        end
    end

    assign int_req = req_q;
    assign int_id  = id_q;
    assign int_vec = vec_q;
    assign IRW     = irw_q;

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// tb/tb_irq_priority_ctrl.sv - self-checking bench for irq_priority_ctrl with a cycle model and directed scenarios
module tb_irq_priority_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  IRQ = 3'b000;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_wdata = 4'b0000;
    logic        int_ack = 1'b0;
    logic        int_ret = 1'b0;
    logic        int_req;
    logic [1:0]  int_id;
    logic [31:0] int_vec;
    logic [2:0]  IRW;

    int errors = 0;
    int checks = 0;

    irq_priority_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .IRQ       (IRQ),
        .cfg_we    (cfg_we),
        .cfg_wdata (cfg_wdata),
        .int_ack   (int_ack),
        .int_ret   (int_ret),
        .int_req   (int_req),
        .int_id    (int_id),
        .int_vec   (int_vec),
        .IRW       (IRW)
    );

    always #5 clk = ~clk;

    // model state: plain bit arrays and integer levels
    bit m_pend [3];
    bit m_irw  [3];
    bit m_mask [3];
    bit m_prev [3];
    bit m_ie   = 1'b1;
    bit m_req  = 1'b0;
    int m_id   = 0;

    function automatic int highest(input bit v [3], input bit gate [3]);
        int h = -1;
        for (int i = 0; i < 3; i++) if (v[i] && gate[i]) h = i;
        return h;
    endfunction

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_pend[i] = 0; m_irw[i] = 0; m_mask[i] = 1; m_prev[i] = 1;
        end
    end

    always @(posedge clk) begin
        bit all1 [3];
        bit np   [3];
        bit nirw [3];
        int cur, cand;
        for (int i = 0; i < 3; i++) all1[i] = 1;
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                m_pend[i] = 0; m_irw[i] = 0; m_mask[i] = 1; m_prev[i] = 1;
            end
            m_ie = 1; m_req = 0; m_id = 0;
        end else begin
            cur  = highest(m_irw, all1);
            cand = highest(m_pend, m_mask);
            np   = m_pend;
            nirw = m_irw;
            if (int_ret && cur >= 0) nirw[cur] = 0;
            if (!m_req) begin
                if (m_ie && cand >= 0 && cand > cur) begin
                    m_req = 1; m_id = cand;
                end
            end else if (int_ack) begin
                np[m_id] = 0; nirw[m_id] = 1; m_req = 0;
            end else if (!m_ie || !m_mask[m_id]) begin
                m_req = 0;
            end
            for (int i = 0; i < 3; i++) begin
                if (IRQ[i] && !m_prev[i]) np[i] = 1;
                m_prev[i] = IRQ[i];
            end
            m_pend = np;
            m_irw  = nirw;
            if (cfg_we) begin
                m_ie = cfg_wdata[3];
                for (int i = 0; i < 3; i++) m_mask[i] = cfg_wdata[i];
            end
        end
    end

    always @(negedge clk) begin
        logic [2:0]  exp_irw;
        logic [31:0] exp_vec;
        for (int i = 0; i < 3; i++) exp_irw[i] = m_irw[i];
        exp_vec = 32'h100 + 32'(m_id) * 32'h10;
        checks += 4;
        if (int_req !== m_req) begin
            errors++; $display("FAIL model_req t=%0t actual=%0b required=%0b", $time, int_req, m_req);
        end
        if (int_id !== 2'(m_id)) begin
            errors++; $display("FAIL model_id t=%0t actual=%0d required=%0d", $time, int_id, m_id);
        end
        if (int_vec !== exp_vec) begin
            errors++; $display("FAIL model_vec t=%0t actual=%h required=%h", $time, int_vec, exp_vec);
        end
        if (IRW !== exp_irw) begin
            errors++; $display("FAIL model_irw t=%0t actual=%b required=%b", $time, IRW, exp_irw);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic pulse(input logic [2:0] v);
        IRQ = v; tick(); IRQ = 3'b000; tick();
    endtask

    task automatic ack1();
        int_ack = 1'b1; tick(); int_ack = 1'b0;
    endtask

    task automatic ret1();
        int_ret = 1'b1; tick(); int_ret = 1'b0;
    endtask

    initial begin
        tick(2);
        chk("reset_req", 32'(int_req), 32'd0);
        chk("reset_id",  32'(int_id),  32'd0);
        chk("reset_vec", int_vec,      32'h100);
        chk("reset_irw", 32'(IRW),     32'd0);
        rst = 1'b0;
        tick();

        // 1: single source, two-cycle latency
        IRQ = 3'b001; tick(); IRQ = 3'b000;
        chk("s1_latency_req", 32'(int_req), 32'd0);
        tick();
        chk("s1_req", 32'(int_req), 32'd1);
        chk("s1_id",  32'(int_id),  32'd0);
        chk("s1_vec", int_vec,      32'h100);
        ack1();
        chk("s1_irw", 32'(IRW), 32'b001);
        chk("s1_req_off", 32'(int_req), 32'd0);

        // 2: nesting above level 0
        pulse(3'b100);
        chk("s2_id",  32'(int_id), 32'd2);
        chk("s2_vec", int_vec,     32'h120);
        ack1();
        chk("s2_irw_nest", 32'(IRW), 32'b101);
        ret1();
        chk("s2_irw_ret1", 32'(IRW), 32'b001);
        ret1();
        chk("s2_irw_ret2", 32'(IRW), 32'b000);

        // 3: lower source blocked until return
        pulse(3'b100); ack1();
        pulse(3'b010); tick();
        chk("s3_blocked", 32'(int_req), 32'd0);
        ret1();
        chk("s3_after_ret_0", 32'(int_req), 32'd0);
        tick();
        chk("s3_req", 32'(int_req), 32'd1);
        chk("s3_id",  32'(int_id),  32'd1);
        chk("s3_vec", int_vec,      32'h110);
        ack1(); ret1();

        // 4: simultaneous edges, highest first
        pulse(3'b101);
        chk("s4_first_id", 32'(int_id), 32'd2);
        ack1(); ret1(); tick();
        chk("s4_second_req", 32'(int_req), 32'd1);
        chk("s4_second_id",  32'(int_id),  32'd0);
        ack1(); ret1();

        // 5: global disable withdraws, re-enable re-requests
        pulse(3'b010);
        cfg_we = 1'b1; cfg_wdata = 4'b0111; tick(); cfg_we = 1'b0;
        tick();
        chk("s5_withdrawn", 32'(int_req), 32'd0);
        tick(2);
        chk("s5_still_off", 32'(int_req), 32'd0);
        cfg_we = 1'b1; cfg_wdata = 4'b1111; tick(); cfg_we = 1'b0;
        tick();
        chk("s5_rereq", 32'(int_req), 32'd1);
        chk("s5_id",    32'(int_id),  32'd1);
        ack1(); ret1();

        // ack ignored in idle; edge during ack keeps source pending
        ack1(); tick();
        chk("idle_ack_irw", 32'(IRW), 32'd0);
        pulse(3'b001);
        IRQ = 3'b001; int_ack = 1'b1; tick(); int_ack = 1'b0; IRQ = 3'b000;
        tick(2);
        chk("edge_ack_noreenter", 32'(int_req), 32'd0);
        ret1(); tick();
        chk("edge_ack_repend", 32'(int_req), 32'd1);
        ack1(); ret1();

        // 6: line held through reset, then reset mid-request
        IRQ = 3'b111; rst = 1'b1; tick(2); rst = 1'b0; tick(3);
        chk("s6_no_req", 32'(int_req), 32'd0);
        IRQ = 3'b000; tick();
        pulse(3'b001);
        chk("s6_req_before_rst", 32'(int_req), 32'd1);
        rst = 1'b1; tick();
        chk("s6_rst_req", 32'(int_req), 32'd0);
        chk("s6_rst_id",  32'(int_id),  32'd0);
        chk("s6_rst_vec", int_vec,      32'h100);
        chk("s6_rst_irw", 32'(IRW),     32'd0);
        rst = 1'b0; tick(3);
        chk("s6_no_replay", 32'(int_req), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
